// File: rtl/mem_responder_pkg.sv
// Shared types and sizing helpers for the memory responder and its channel FSMs.
package mem_responder_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} resp_state_t;

   // Counter holds LATENCY-1 at most; never narrower than one bit.
   function automatic int lat_cnt_bits(input int lat);
      return (lat <= 2) ? 1 : $clog2(lat);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Valid/ready memory channel bundle plus the backdoor preload port.
interface mem_responder_if #(
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 8,
   parameter int NUM_CHANNELS = 4
);
   logic [NUM_CHANNELS-1:0]                read_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address;
   logic [NUM_CHANNELS-1:0]                read_ready;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data;
   logic [NUM_CHANNELS-1:0]                write_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data;
   logic [NUM_CHANNELS-1:0]                write_ready;
   logic                                   load_en;
   logic [ADDR_BITS-1:0]                   load_address;
   logic [DATA_BITS-1:0]                   load_data;

   modport master (
      output read_valid, read_address, write_valid, write_address, write_data,
             load_en, load_address, load_data,
      input  read_ready, read_data, write_ready
   );

   modport slave (
      input  read_valid, read_address, write_valid, write_address, write_data,
             load_en, load_address, load_data,
      output read_ready, read_data, write_ready
   );
endinterface

// File: rtl/mem_resp_channel.sv
// One request direction of one channel: IDLE/BUSY/RESP/DRAIN FSM with latency counter.
module mem_resp_channel
   import mem_responder_pkg::*;
#(
   parameter int LATENCY  = 2,
   parameter int CNT_BITS = lat_cnt_bits(LATENCY)
) (
   input  logic clk,
   input  logic reset,
   input  logic valid,
   output logic accept,
   output logic commit,
   output logic ready
);
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

   resp_state_t         r_state;
   logic [CNT_BITS-1:0] r_cnt;
   logic                r_ready;

   // accept/commit are same-edge strobes for the owner's latches and store access.
   assign accept = (r_state == IDLE) && valid;
   assign commit = (r_state == BUSY) && (r_cnt == '0);
   assign ready  = r_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (valid) begin
                  r_state <= BUSY;
                  r_cnt   <= CNT_LOAD;
               end
            end
            BUSY: begin
               if (r_cnt == '0) begin
                  r_state <= RESP;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP:    r_state <= DRAIN;
            // Wait for the requester to drop valid so one request is served once.
            DRAIN:   if (!valid) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/mem_responder.sv
// Multi-channel memory responder: register-array store served by per-channel
// read and write FSMs with fixed programmable latency.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CHANNELS  = 4,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 2
) (
   input  logic            clk,
   input  logic            reset,
   mem_responder_if.slave  bus
);
   localparam int CNT_BITS = lat_cnt_bits(max_int(READ_LATENCY, WRITE_LATENCY));
   localparam int DEPTH    = 2 ** ADDR_BITS;

   logic [DATA_BITS-1:0] r_mem [DEPTH];

   logic [NUM_CHANNELS-1:0]                w_rd_accept, w_rd_commit, w_rd_ready;
   logic [NUM_CHANNELS-1:0]                w_wr_accept, w_wr_commit, w_wr_ready;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] w_wr_addr;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] w_wr_data;

   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
         logic [ADDR_BITS-1:0] r_rd_addr;
         logic [ADDR_BITS-1:0] r_wr_addr;
         logic [DATA_BITS-1:0] r_wr_data;
         logic [DATA_BITS-1:0] r_rd_data;

         mem_resp_channel #(.LATENCY(READ_LATENCY), .CNT_BITS(CNT_BITS)) u_rd (
            .clk    (clk),
            .reset  (reset),
            .valid  (bus.read_valid[gi]),
            .accept (w_rd_accept[gi]),
            .commit (w_rd_commit[gi]),
            .ready  (w_rd_ready[gi])
         );

         mem_resp_channel #(.LATENCY(WRITE_LATENCY), .CNT_BITS(CNT_BITS)) u_wr (
            .clk    (clk),
            .reset  (reset),
            .valid  (bus.write_valid[gi]),
            .accept (w_wr_accept[gi]),
            .commit (w_wr_commit[gi]),
            .ready  (w_wr_ready[gi])
         );

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_rd_addr <= '0;
               r_wr_addr <= '0;
               r_wr_data <= '0;
               r_rd_data <= '0;
            end else begin
               if (w_rd_accept[gi]) r_rd_addr <= bus.read_address[gi];
               if (w_wr_accept[gi]) begin
                  r_wr_addr <= bus.write_address[gi];
                  r_wr_data <= bus.write_data[gi];
               end
               // Sampled before this edge's writes land, so same-edge writes read old data.
               if (w_rd_commit[gi]) r_rd_data <= r_mem[r_rd_addr];
            end
         end

         assign w_wr_addr[gi]     = r_wr_addr;
         assign w_wr_data[gi]     = r_wr_data;
         assign bus.read_data[gi] = r_rd_data;
      end
   endgenerate

   assign bus.read_ready  = w_rd_ready;
   assign bus.write_ready = w_wr_ready;

   // Later assignments win: preload first, then channels from highest index down.
   always_ff @(posedge clk) begin
      if (bus.load_en) r_mem[bus.load_address] <= bus.load_data;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (w_wr_commit[i]) r_mem[w_wr_addr[i]] <= w_wr_data[i];
      end
   end
endmodule
